// File: rtl/imem_responder_if.sv
// Request/response channel between the fetch unit and the instruction memory.
// The fetch side is the master; the memory responder is the slave.
interface imem_responder_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic [ADDR_W-1:0] resp_addr;
    logic              resp_err;
    logic              resp_ready;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_addr, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_addr, resp_err
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency, in-order, stallable read pipeline
// with a program-load write port and a flush for branch redirects.
module imem_responder #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 2
) (
    input  logic              i_clock,
    input  logic              i_reset,
    imem_responder_if.slave   bus,
    input  logic              i_flush,
    input  logic              i_load_en,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W-1:0] i_load_data
);
    localparam int              MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_stall;
    logic              w_req_ready;
    logic              w_accept;
    logic              w_req_oob;
    logic              w_load_ok;
    logic              w_resp_valid;
    logic [MEM_AW-1:0] w_rd_idx;
    logic [MEM_AW-1:0] w_wr_idx;
    logic [DATA_W-1:0] w_rd_data;

    assign w_stall     = w_resp_valid && !bus.resp_ready;
    assign w_req_ready = !w_stall && !i_load_en && !i_flush && i_reset;
    assign w_accept    = bus.req_valid && w_req_ready;

    // Range checks are done on the full address so aliasing into the array is impossible.
    assign w_req_oob = ({1'b0, bus.req_addr} >= DEPTH_EXT);
    assign w_load_ok = i_load_en && ({1'b0, i_load_addr} < DEPTH_EXT);
    assign w_rd_idx  = bus.req_addr[MEM_AW-1:0];
    assign w_wr_idx  = i_load_addr[MEM_AW-1:0];
    assign w_rd_data = w_req_oob ? '0 : r_mem[w_rd_idx];

    // Memory is never reset; stage 0 captures the pre-write word on a shared edge.
    always_ff @(posedge i_clock) begin
        if (w_load_ok) begin
            r_mem[w_wr_idx] <= i_load_data;
        end
    end

    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
        logic              r_valid;
        logic [ADDR_W-1:0] r_addr;
        logic [DATA_W-1:0] r_data;
        logic              r_err;
        logic              w_in_valid;
        logic [ADDR_W-1:0] w_in_addr;
        logic [DATA_W-1:0] w_in_data;
        logic              w_in_err;

        if (gi == 0) begin : g_head
            assign w_in_valid = w_accept;
            assign w_in_addr  = bus.req_addr;
            assign w_in_data  = w_rd_data;
            assign w_in_err   = w_req_oob;
        end else begin : g_body
            assign w_in_valid = g_stage[gi-1].r_valid;
            assign w_in_addr  = g_stage[gi-1].r_addr;
            assign w_in_data  = g_stage[gi-1].r_data;
            assign w_in_err   = g_stage[gi-1].r_err;
        end

        // Flush wins over stall; a stall freezes every stage so nothing is lost or repeated.
        always_ff @(posedge i_clock or negedge i_reset) begin
            if (!i_reset) begin
                r_valid <= 1'b0;
                r_addr  <= '0;
                r_data  <= '0;
                r_err   <= 1'b0;
            end else if (i_flush) begin
                r_valid <= 1'b0;
            end else if (!w_stall) begin
                r_valid <= w_in_valid;
                if (w_in_valid) begin
                    r_addr <= w_in_addr;
                    r_data <= w_in_data;
                    r_err  <= w_in_err;
                end
            end
        end
    end

    assign w_resp_valid   = g_stage[LATENCY-1].r_valid;
    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_data  = g_stage[LATENCY-1].r_data;
    assign bus.resp_addr  = g_stage[LATENCY-1].r_addr;
    assign bus.resp_err   = g_stage[LATENCY-1].r_err;
endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: table-driven stream, scoreboard
// monitor, and hand-written stall/flush/load/out-of-range/reset sequences.
module tb_imem_responder;
    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int LAT1 = 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush, flush1;
    logic          ld_en, ld1_en;
    logic [AW-1:0] ld_addr, ld1_addr;
    logic [DW-1:0] ld_data, ld1_data;
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    imem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    imem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4096), .LATENCY(LAT)) dut0 (
        .i_clock(clk), .i_reset(rst_n), .bus(bus0), .i_flush(flush),
        .i_load_en(ld_en), .i_load_addr(ld_addr), .i_load_data(ld_data)
    );

    imem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(8), .LATENCY(LAT1)) dut1 (
        .i_clock(clk), .i_reset(rst_n), .bus(bus1), .i_flush(flush1),
        .i_load_en(ld1_en), .i_load_addr(ld1_addr), .i_load_data(ld1_data)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          err;
        bit            lat;
        int            acc_cyc;
    } exp_t;

    vec_t vecs [10];
    exp_t sb [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Offer one request; push the expected response when the handshake is seen.
    task automatic do_req(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit lat);
        int  n  = 0;
        bit  ok = 0;
        bus0.req_valid = 1'b1;
        bus0.req_addr  = a;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (bus0.req_ready) ok = 1;
            n++;
        end
        if (ok) begin
            sb.push_back('{addr: a, data: d, err: 1'b0, lat: lat, acc_cyc: cyc});
            $display("[TB] req addr=%0h accepted at cycle %0d", a, cyc);
        end else begin
            check("req_accept_timeout", 64'd0, 64'd1);
        end
        @(posedge clk); #1;
    endtask

    task automatic load0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk); #1;
        ld_en   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compares every completed response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus0.resp_valid && bus0.resp_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got addr=%0h data=%0h, required no response",
                             bus0.resp_addr, bus0.resp_data);
                end else begin
                    e = sb.pop_front();
                    $display("[TB] resp addr=%0h data=%08h err=%0b cycle %0d",
                             bus0.resp_addr, bus0.resp_data, bus0.resp_err, cyc);
                    check("resp_payload", {19'd0, bus0.resp_err, bus0.resp_addr, bus0.resp_data},
                          {19'd0, e.err, e.addr, e.data});
                    if (e.lat) check("resp_latency", 64'(cyc - e.acc_cyc), 64'(LAT));
                end
            end
            if (rst_n && flush) sb.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        bit  seen;

        flush = 0; flush1 = 0;
        ld_en = 0; ld_addr = '0; ld_data = '0;
        ld1_en = 0; ld1_addr = '0; ld1_data = '0;
        bus0.req_valid = 0; bus0.req_addr = '0; bus0.resp_ready = 1;
        bus1.req_valid = 0; bus1.req_addr = '0; bus1.resp_ready = 1;

        vecs[0] = '{12'd0,    32'hA000_0000};
        vecs[1] = '{12'd1,    32'hA000_0001};
        vecs[2] = '{12'd2,    32'hA000_0002};
        vecs[3] = '{12'd3,    32'hA000_0003};
        vecs[4] = '{12'd5,    32'h5555_0005};
        vecs[5] = '{12'd6,    32'h6666_0006};
        vecs[6] = '{12'd7,    32'h7777_0007};
        vecs[7] = '{12'd100,  32'hC0DE_0064};
        vecs[8] = '{12'd2048, 32'h8000_0800};
        vecs[9] = '{12'd4095, 32'hFFFF_0FFF};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", bus0.resp_valid, 0);
        check("rst_resp_data",  bus0.resp_data, 0);
        check("rst_resp_addr",  bus0.resp_addr, 0);
        check("rst_resp_err",   bus0.resp_err, 0);
        check("rst_req_ready",  bus0.req_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", bus0.req_ready, 1);
        @(posedge clk); #1;

        // Program load, then back-to-back stream over the whole table
        for (int i = 0; i < 10; i++) load0(vecs[i].addr, vecs[i].data);
        for (int i = 0; i < 10; i++) do_req(vecs[i].addr, vecs[i].data, 1'b1);
        bus0.req_valid = 1'b0;
        drain();

        // Stall for 3 cycles while addr 1 is at the output
        fork
            begin
                for (int i = 0; i < 4; i++) do_req(vecs[i].addr, vecs[i].data, 1'b0);
                bus0.req_valid = 1'b0;
            end
            begin
                n = 0; seen = 0;
                while (!seen && n < 30) begin
                    @(posedge clk); #1;
                    n++;
                    if (bus0.resp_valid && bus0.resp_addr == 12'd1) seen = 1;
                end
                check("stall_seen_addr1", seen, 1);
                bus0.resp_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_valid",     bus0.resp_valid, 1);
                    check("stall_data",      bus0.resp_data, 32'hA000_0001);
                    check("stall_addr",      bus0.resp_addr, 1);
                    check("stall_req_ready", bus0.req_ready, 0);
                end
                @(posedge clk); #1;
                bus0.resp_ready = 1'b1;
            end
        join
        drain();

        // Flush two in-flight requests while the output is stalled
        bus0.resp_ready = 1'b0;
        do_req(12'd5, 32'h5555_0005, 1'b0);
        do_req(12'd6, 32'h6666_0006, 1'b0);
        bus0.req_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("flush_req_ready", bus0.req_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_resp_valid", bus0.resp_valid, 0);
        bus0.resp_ready = 1'b1;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus0.resp_valid) n++;
        end
        check("flush_no_resp", 64'(n), 64'd0);
        @(posedge clk); #1;
        do_req(12'd7, 32'h7777_0007, 1'b1);
        bus0.req_valid = 1'b0;
        drain();

        // Load and request collide: request must wait, then see the new word
        bus0.req_valid = 1'b1;
        bus0.req_addr  = 12'd9;
        ld_en   = 1'b1;
        ld_addr = 12'd9;
        ld_data = 32'h1234_5678;
        @(negedge clk);
        check("load_req_ready", bus0.req_ready, 0);
        @(posedge clk); #1;
        ld_en = 1'b0;
        do_req(12'd9, 32'h1234_5678, 1'b1);
        bus0.req_valid = 1'b0;
        drain();

        // In-flight read keeps its data when the word is overwritten next cycle
        do_req(12'd3, 32'hA000_0003, 1'b1);
        bus0.req_valid = 1'b0;
        load0(12'd3, 32'h3333_3333);
        drain();
        do_req(12'd3, 32'h3333_3333, 1'b1);
        bus0.req_valid = 1'b0;
        drain();

        // DEPTH=8, LATENCY=1 instance: out-of-range request and ignored high load
        ld1_en = 1'b1; ld1_addr = 12'd2;  ld1_data = 32'h0000_BEEF;
        @(posedge clk); #1;
        ld1_addr = 12'd10; ld1_data = 32'hDEAD_0000;
        @(posedge clk); #1;
        ld1_en = 1'b0;
        bus1.req_valid = 1'b1;
        bus1.req_addr  = 12'd12;
        @(negedge clk);
        check("d8_req_ready", bus1.req_ready, 1);
        @(posedge clk); #1;
        bus1.req_addr = 12'd2;
        $display("[TB] d8 resp addr=%0h data=%08h err=%0b", bus1.resp_addr, bus1.resp_data, bus1.resp_err);
        check("d8_oob_valid", bus1.resp_valid, 1);
        check("d8_oob_data",  bus1.resp_data, 0);
        check("d8_oob_err",   bus1.resp_err, 1);
        check("d8_oob_addr",  bus1.resp_addr, 12);
        @(posedge clk); #1;
        bus1.req_valid = 1'b0;
        $display("[TB] d8 resp addr=%0h data=%08h err=%0b", bus1.resp_addr, bus1.resp_data, bus1.resp_err);
        check("d8_in_valid", bus1.resp_valid, 1);
        check("d8_in_data",  bus1.resp_data, 32'h0000_BEEF);
        check("d8_in_err",   bus1.resp_err, 0);
        check("d8_in_addr",  bus1.resp_addr, 2);
        @(posedge clk); #1;
        check("d8_idle_valid", bus1.resp_valid, 0);

        // Asynchronous reset mid-cycle with two requests in flight
        do_req(12'd0, 32'hA000_0000, 1'b0);
        do_req(12'd1, 32'hA000_0001, 1'b0);
        bus0.req_valid = 1'b0;
        check("prerst_resp_valid", bus0.resp_valid, 1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("arst_resp_valid", bus0.resp_valid, 0);
        check("arst_resp_data",  bus0.resp_data, 0);
        check("arst_resp_addr",  bus0.resp_addr, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(12'd0, 32'hA000_0000, 1'b1);
        bus0.req_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
